// File: rtl/swt16_pkg.sv
// Shared SWT16 execute-stage definitions: ALU opcodes and execute FSM state encoding.
package swt16_pkg;

    localparam int ALU_OP_WIDTH = 4;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_NOP   = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD   = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB   = 4'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND   = 4'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR    = 4'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR   = 4'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL   = 4'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL   = 4'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA   = 4'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_PASS2 = 4'd9;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL   = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } exec_state_t;

endpackage

// File: rtl/ialu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, W cycles per product,
// keeping the low W bits. Used by exec_mc only when EXEC_MUL_EN is defined.
module ialu_mul_iter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [CW-1:0] count;

    // product holds its final value after the last step until the next start
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy    <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            product <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            mcand   <= a;
            mplier  <= b;
            count   <= '0;
            product <= '0;
        end else if (busy) begin
            if (mplier[0]) begin
                product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

    assign done = busy && (count == CW'(W - 1));

endmodule

// File: rtl/exec_mc.sv
// SWT16 multi-cycle execute stage: registered operands, opcode-driven ALU, jump and
// data-memory side effects. Define EXEC_MUL_EN to add the stalling iterative multiplier.
module exec_mc
    import swt16_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_WORD_WIDTH = 16,
    parameter int IALU_WORD_WIDTH = 16,
    parameter int ALU_OP_WIDTH    = 4,
    parameter int PC_WIDTH        = 12,
    parameter int PMEM_ADDR_WIDTH = 12,
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [ALU_OP_WIDTH-1:0]    in_alu_op,
    input  logic                       in_act_jump_to_ialu_res,
    input  logic                       in_act_load_dmem,
    input  logic                       in_act_store_dmem,
    input  logic                       in_act_write_res_to_reg,
    input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    input  logic [IALU_WORD_WIDTH-1:0] in_src1,
    input  logic [IALU_WORD_WIDTH-1:0] in_src2,
    output logic                       out_stall,
    output logic                       out_valid,
    output logic                       out_act_load_dmem,
    output logic                       out_act_store_dmem,
    output logic                       out_act_write_res_to_reg,
    output logic                       out_set_pc,
    output logic                       out_flush,
    output logic [PMEM_ADDR_WIDTH-1:0] out_branch_pc,
    output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_rd_addr,
    output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_wr_addr,
    output logic [DMEM_WORD_WIDTH-1:0] out_dmem_wr_word,
    output logic [IALU_WORD_WIDTH-1:0] out_res,
    output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
    output logic [PMEM_WORD_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]        out_pc
);

    localparam int W   = IALU_WORD_WIDTH;
    localparam int SHW = $clog2(W);

    logic                       r_valid;
    logic [ALU_OP_WIDTH-1:0]    r_op;
    logic                       r_jmp, r_ld, r_st, r_wr;
    logic [PMEM_WORD_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0]        r_pc;
    logic [REG_IDX_WIDTH-1:0]   r_idx;
    logic [W-1:0]               r_src1, r_src2;

    exec_state_t  state;
    logic [W-1:0] alu_res;
    logic         op_known;
    logic         side_ok;
    logic [SHW-1:0] shamt;

    // A bubble is captured as all-zero so every output naturally reads 0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_op    <= '0;
            r_jmp   <= 1'b0;
            r_ld    <= 1'b0;
            r_st    <= 1'b0;
            r_wr    <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
            r_idx   <= '0;
            r_src1  <= '0;
            r_src2  <= '0;
        end else if (!out_stall) begin
            r_valid <= in_valid;
            r_op    <= in_valid ? in_alu_op : '0;
            r_jmp   <= in_valid && in_act_jump_to_ialu_res;
            r_ld    <= in_valid && in_act_load_dmem;
            r_st    <= in_valid && in_act_store_dmem;
            r_wr    <= in_valid && in_act_write_res_to_reg;
            r_instr <= in_valid ? in_instr : '0;
            r_pc    <= in_valid ? in_pc : '0;
            r_idx   <= in_valid ? in_res_reg_idx : '0;
            r_src1  <= in_valid ? in_src1 : '0;
            r_src2  <= in_valid ? in_src2 : '0;
        end
    end

`ifdef EXEC_MUL_EN
    logic         mul_start, mul_busy, mul_done;
    logic [W-1:0] mul_product;

    assign mul_start = !out_stall && in_valid && (in_alu_op == ALU_MUL);

    ialu_mul_iter #(.W(W)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (in_src1),
        .b       (in_src2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // DONE also samples the next instruction, so back-to-back MULs have no gap
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: state <= mul_start ? ST_MUL : ST_IDLE;
                ST_MUL:           if (mul_done || !mul_busy) state <= ST_DONE;
                default:          state <= ST_IDLE;
            endcase
        end
    end

    assign out_stall = (state == ST_MUL);
`else
    assign state     = ST_IDLE;
    assign out_stall = 1'b0;
`endif

    assign shamt = r_src2[SHW-1:0];

    always_comb begin
        alu_res  = '0;
        op_known = 1'b1;
        case (r_op)
            ALU_NOP:   alu_res = '0;
            ALU_ADD:   alu_res = r_src1 + r_src2;
            ALU_SUB:   alu_res = r_src1 - r_src2;
            ALU_AND:   alu_res = r_src1 & r_src2;
            ALU_OR:    alu_res = r_src1 | r_src2;
            ALU_XOR:   alu_res = r_src1 ^ r_src2;
            ALU_SLL:   alu_res = r_src1 << shamt;
            ALU_SRL:   alu_res = r_src1 >> shamt;
            ALU_SRA:   alu_res = $unsigned($signed(r_src1) >>> shamt);
            ALU_PASS2: alu_res = r_src2;
`ifdef EXEC_MUL_EN
            ALU_MUL:   alu_res = mul_product;
`endif
            default:   op_known = 1'b0;
        endcase
    end

    // Undefined opcodes complete as valid but must not touch PC, memory or registers
    assign out_valid = r_valid && (state != ST_MUL);
    assign side_ok   = out_valid && op_known;

    assign out_act_load_dmem        = side_ok && r_ld;
    assign out_act_store_dmem       = side_ok && r_st;
    assign out_act_write_res_to_reg = side_ok && r_wr;
    assign out_set_pc               = side_ok && r_jmp;
    assign out_flush                = side_ok && r_jmp;
    assign out_branch_pc    = out_set_pc ? alu_res[PMEM_ADDR_WIDTH-1:0] : '0;
    assign out_dmem_rd_addr = out_act_load_dmem ? r_src1[DMEM_ADDR_WIDTH-1:0] : '0;
    assign out_dmem_wr_addr = out_act_store_dmem ? r_src2[DMEM_ADDR_WIDTH-1:0] : '0;
    assign out_dmem_wr_word = out_act_store_dmem ? r_src1 : '0;
    assign out_res          = out_valid ? alu_res : '0;
    assign out_res_reg_idx  = out_valid ? r_idx : '0;
    assign out_instr        = out_valid ? r_instr : '0;
    assign out_pc           = out_valid ? r_pc : '0;

endmodule

// File: tb/tb_exec_mc.sv
// Scoreboard bench for exec_mc: stimulus pushes expected results, a negedge monitor pops and checks.
`timescale 1ns/1ps
module tb_exec_mc;
    import swt16_pkg::*;

    localparam int W = 16;
`ifdef EXEC_MUL_EN
    localparam int   MUL_LAT   = W + 1;
    localparam logic MUL_KNOWN = 1'b1;
    localparam int   MUL_STALL = W;
`else
    localparam int   MUL_LAT   = 1;
    localparam logic MUL_KNOWN = 1'b0;
    localparam int   MUL_STALL = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_alu_op = '0;
    logic        in_act_jump_to_ialu_res = 1'b0;
    logic        in_act_load_dmem = 1'b0;
    logic        in_act_store_dmem = 1'b0;
    logic        in_act_write_res_to_reg = 1'b0;
    logic [15:0] in_instr = '0;
    logic [11:0] in_pc = '0;
    logic [3:0]  in_res_reg_idx = '0;
    logic [15:0] in_src1 = '0;
    logic [15:0] in_src2 = '0;

    logic        out_stall, out_valid;
    logic        out_act_load_dmem, out_act_store_dmem, out_act_write_res_to_reg;
    logic        out_set_pc, out_flush;
    logic [11:0] out_branch_pc, out_dmem_rd_addr, out_dmem_wr_addr;
    logic [15:0] out_dmem_wr_word, out_res, out_instr;
    logic [3:0]  out_res_reg_idx;
    logic [11:0] out_pc;

    exec_mc dut (
        .clock                    (clock),
        .reset                    (reset),
        .in_valid                 (in_valid),
        .in_alu_op                (in_alu_op),
        .in_act_jump_to_ialu_res  (in_act_jump_to_ialu_res),
        .in_act_load_dmem         (in_act_load_dmem),
        .in_act_store_dmem        (in_act_store_dmem),
        .in_act_write_res_to_reg  (in_act_write_res_to_reg),
        .in_instr                 (in_instr),
        .in_pc                    (in_pc),
        .in_res_reg_idx           (in_res_reg_idx),
        .in_src1                  (in_src1),
        .in_src2                  (in_src2),
        .out_stall                (out_stall),
        .out_valid                (out_valid),
        .out_act_load_dmem        (out_act_load_dmem),
        .out_act_store_dmem       (out_act_store_dmem),
        .out_act_write_res_to_reg (out_act_write_res_to_reg),
        .out_set_pc               (out_set_pc),
        .out_flush                (out_flush),
        .out_branch_pc            (out_branch_pc),
        .out_dmem_rd_addr         (out_dmem_rd_addr),
        .out_dmem_wr_addr         (out_dmem_wr_addr),
        .out_dmem_wr_word         (out_dmem_wr_word),
        .out_res                  (out_res),
        .out_res_reg_idx          (out_res_reg_idx),
        .out_instr                (out_instr),
        .out_pc                   (out_pc)
    );

    typedef struct {
        string       name;
        logic [15:0] res;
        logic        jmp, ld, st, wr;
        logic [11:0] branch, rd, wra;
        logic [15:0] wword;
        logic [3:0]  idx;
        logic [15:0] instr;
        logic [11:0] pc;
        int          cycle;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   seq = 0;
    int   nChecks = 0;
    int   nFails = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [3:0] op,
                                 input logic [15:0] s1, input logic [15:0] s2,
                                 input logic jmp, input logic ld, input logic st, input logic wr,
                                 input logic known, input logic [15:0] res, input int lat);
        exp_t e;
        seq++;
        in_valid = 1'b1;
        in_alu_op = op;
        in_src1 = s1;
        in_src2 = s2;
        in_act_jump_to_ialu_res = jmp;
        in_act_load_dmem = ld;
        in_act_store_dmem = st;
        in_act_write_res_to_reg = wr;
        in_res_reg_idx = 4'(seq);
        in_instr = {op, 12'(seq)};
        in_pc = 12'(seq * 4);
        e.name   = name;
        e.res    = res;
        e.jmp    = known && jmp;
        e.branch = e.jmp ? res[11:0] : 12'h000;
        e.ld     = known && ld;
        e.rd     = e.ld ? s1[11:0] : 12'h000;
        e.st     = known && st;
        e.wra    = e.st ? s2[11:0] : 12'h000;
        e.wword  = e.st ? s1 : 16'h0000;
        e.wr     = known && wr;
        e.idx    = 4'(seq);
        e.instr  = {op, 12'(seq)};
        e.pc     = 12'(seq * 4);
        e.cycle  = cyc + lat;
        sb.push_back(e);
        @(posedge clock); #1;
    endtask

    task automatic applyBubble();
        in_valid = 1'b0;
        @(posedge clock); #1;
    endtask

    // Drives a different valid instruction while stalled; it must be ignored
    task automatic waitStall(input string name, input int expCycles);
        int n = 0;
        in_valid = 1'b1;
        in_alu_op = ALU_ADD;
        in_src1 = 16'h0007;
        in_src2 = 16'h0007;
        in_act_write_res_to_reg = 1'b1;
        while (out_stall && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        checkOutput({name, "_stall_cycles"}, 32'(n), 32'(expCycles));
        in_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.cycle));
                    checkOutput({mon_e.name, "_res"}, {16'h0, out_res}, {16'h0, mon_e.res});
                    checkOutput({mon_e.name, "_jump"}, {18'h0, out_set_pc, out_flush, out_branch_pc},
                                {18'h0, mon_e.jmp, mon_e.jmp, mon_e.branch});
                    checkOutput({mon_e.name, "_dmem_addr"}, {8'h0, out_dmem_rd_addr, out_dmem_wr_addr},
                                {8'h0, mon_e.rd, mon_e.wra});
                    checkOutput({mon_e.name, "_dmem_word"}, {16'h0, out_dmem_wr_word}, {16'h0, mon_e.wword});
                    checkOutput({mon_e.name, "_acts"},
                                {29'h0, out_act_load_dmem, out_act_store_dmem, out_act_write_res_to_reg},
                                {29'h0, mon_e.ld, mon_e.st, mon_e.wr});
                    checkOutput({mon_e.name, "_tag"}, {out_res_reg_idx, out_pc, out_instr},
                                {mon_e.idx, mon_e.pc, mon_e.instr});
                end
            end else begin
                checkOutput("idle_side_effects",
                            {31'h0, |{out_set_pc, out_flush, out_act_load_dmem, out_act_store_dmem,
                                      out_act_write_res_to_reg, out_branch_pc, out_dmem_rd_addr,
                                      out_dmem_wr_addr, out_dmem_wr_word}}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock); #2 reset = 1'b1;
        @(posedge clock); #1;
        checkOutput("reset_outputs",
                    {31'h0, |{out_stall, out_valid, out_act_load_dmem, out_act_store_dmem,
                              out_act_write_res_to_reg, out_set_pc, out_flush, out_branch_pc,
                              out_dmem_rd_addr, out_dmem_wr_addr, out_dmem_wr_word, out_res,
                              out_res_reg_idx, out_instr, out_pc}}, 32'd0);

        applyStimulus("add_wrap",  ALU_ADD,  16'hFFFF, 16'h0002, 0, 0, 0, 1, 1, 16'h0001, 1);
        applyStimulus("sub_neg",   ALU_SUB,  16'h0003, 16'h0005, 0, 0, 0, 1, 1, 16'hFFFE, 1);
        applyStimulus("sra",       ALU_SRA,  16'h8000, 16'h0004, 0, 0, 0, 1, 1, 16'hF800, 1);
        applyStimulus("sll15",     ALU_SLL,  16'h0001, 16'h000F, 0, 0, 0, 1, 1, 16'h8000, 1);
        applyStimulus("srl",       ALU_SRL,  16'h8000, 16'h0004, 0, 0, 0, 1, 1, 16'h0800, 1);
        applyStimulus("and",       ALU_AND,  16'hF0F0, 16'h0FF0, 0, 0, 0, 1, 1, 16'h00F0, 1);
        applyStimulus("or",        ALU_OR,   16'hF000, 16'h000F, 0, 0, 0, 1, 1, 16'hF00F, 1);
        applyStimulus("xor",       ALU_XOR,  16'hFFFF, 16'h00FF, 0, 0, 0, 1, 1, 16'hFF00, 1);
        applyStimulus("undef15",   4'd15,    16'h1234, 16'h5678, 1, 1, 1, 1, 0, 16'h0000, 1);
        applyStimulus("load",      ALU_ADD,  16'h1234, 16'h0000, 0, 1, 0, 1, 1, 16'h1234, 1);
        applyStimulus("store",     ALU_NOP,  16'hBEEF, 16'h0567, 0, 0, 1, 0, 1, 16'h0000, 1);
        applyStimulus("jump",      ALU_PASS2,16'h0000, 16'h0ABC, 1, 0, 0, 0, 1, 16'h0ABC, 1);
        applyBubble();
        applyBubble();

        applyStimulus("mul",  ALU_MUL, 16'h0123, 16'h0011, 0, 0, 0, 1, MUL_KNOWN,
                          MUL_KNOWN ? 16'h1353 : 16'h0000, MUL_LAT);
        waitStall("mul", MUL_STALL);
        applyStimulus("mul_b2b_a", ALU_MUL, 16'h0002, 16'h0003, 0, 0, 0, 1, MUL_KNOWN,
                          MUL_KNOWN ? 16'h0006 : 16'h0000, MUL_LAT);
        waitStall("mul_b2b_a", MUL_STALL);
        applyStimulus("mul_b2b_zero", ALU_MUL, 16'h0000, 16'h0055, 0, 0, 0, 1, MUL_KNOWN,
                          16'h0000, MUL_LAT);
        waitStall("mul_b2b_zero", MUL_STALL);
        applyBubble();
        applyBubble();

        applyStimulus("mul_reset", ALU_MUL, 16'h00FF, 16'h0101, 0, 0, 0, 1, MUL_KNOWN,
                          MUL_KNOWN ? 16'hFFFF : 16'h0000, MUL_LAT);
        in_valid = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        reset = 1'b0;
        #1;
        checkOutput("reset_mid_mul",
                    {31'h0, |{out_stall, out_valid, out_act_load_dmem, out_act_store_dmem,
                              out_act_write_res_to_reg, out_set_pc, out_flush, out_branch_pc,
                              out_dmem_rd_addr, out_dmem_wr_addr, out_dmem_wr_word, out_res,
                              out_res_reg_idx, out_instr, out_pc}}, 32'd0);
        sb.delete();
        @(negedge clock); #2 reset = 1'b1;
        @(posedge clock); #1;

        applyStimulus("add_after_reset", ALU_ADD, 16'h0001, 16'h0001, 0, 0, 0, 1, 1, 16'h0002, 1);
        applyBubble();
        applyBubble();
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/exec_mc.md
# exec_mc

Multi-cycle execute stage of the SWT16 pipeline, sitting between decode/operand fetch and memory/writeback. It registers one decoded instruction per cycle and evaluates a selectable integer ALU operation. It resolves jumps and drives data-memory addresses. An optional iterative multiplier stalls upstream stages through a handshake while it runs. It is the parametrised successor of the single-cycle add/forward execute stage: opcode-driven ALU, valid tracking, and stall support.

## Interface
- DMEM_ADDR_WIDTH, 12, data memory address width
- DMEM_WORD_WIDTH, 16, data memory word width (equals IALU_WORD_WIDTH)
- IALU_WORD_WIDTH, 16, ALU operand/result width W
- ALU_OP_WIDTH, 4, width of ALU opcode
- PC_WIDTH, 12, program counter width
- PMEM_ADDR_WIDTH, 12, program memory address width
- PMEM_WORD_WIDTH, 16, instruction word width
- REG_IDX_WIDTH, 4, register index width
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream slot holds a real instruction
- in_alu_op  in  ALU_OP_WIDTH  operation select
- in_act_jump_to_ialu_res / in_act_load_dmem / in_act_store_dmem / in_act_write_res_to_reg  in  1 each  decoded actions
- in_instr  in  PMEM_WORD_WIDTH  instruction word; in_pc  in  PC_WIDTH  its PC
- in_res_reg_idx  in  REG_IDX_WIDTH  destination register
- in_src1, in_src2  in  W  operands
- out_stall  out  1  upstream must hold all inputs stable
- out_valid  out  1  outputs below carry a completed instruction
- out_act_load_dmem / out_act_store_dmem / out_act_write_res_to_reg  out  1 each  registered actions, gated by out_valid
- out_set_pc, out_flush  out  1  jump taken; out_branch_pc  out  PMEM_ADDR_WIDTH  target
- out_dmem_rd_addr, out_dmem_wr_addr  out  DMEM_ADDR_WIDTH; out_dmem_wr_word  out  DMEM_WORD_WIDTH
- out_res  out  W; out_res_reg_idx  out  REG_IDX_WIDTH; out_instr, out_pc  out  registered copies

## Operation
- Opcodes: 0 NOP (res 0), 1 ADD, 2 SUB (src1-src2), 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA (shift amount src2[log2(W)-1:0]), 9 PASS2 (res=src2), 10 MUL (low W bits of src1*src2). Undefined codes yield res 0 and no side effects.
- All arithmetic is modulo 2^W; carries and overflow are discarded.
- Jump: out_set_pc=out_flush=1, out_branch_pc=out_res[PMEM_ADDR_WIDTH-1:0].
- Load: out_dmem_rd_addr=src1 low bits. Store: out_dmem_wr_addr=src2 low bits, out_dmem_wr_word=src1.
- Every side-effect output and out_act_* is 0 unless out_valid=1. Inactive address/data outputs are 0.
- FSM states:
  - IDLE: single-cycle op.
  - MUL: shift-add, one multiplier bit per cycle, counter 0..W-1.
  - DONE: product presented.
- Transitions:
  - IDLE→MUL on a sampled valid MUL.
  - MUL→DONE when counter=W-1.
  - DONE→IDLE on the next edge, which also samples new inputs.

## Timing
- Reset (asynchronous, active-low) forces all outputs and registers to 0 and the FSM to IDLE, including mid-MUL. The partial product is discarded.
- Inputs are sampled on the rising edge when out_stall=0. They are ignored while out_stall=1.
- Single-cycle ops: outputs are valid in the cycle after sampling (latency 1). Results are combinational from the sampling registers.
- MUL: out_stall=1 and out_valid=0 for W cycles after sampling. In the next cycle (DONE) out_valid=1, out_stall=0, and out_res=product. Total latency is W+1.
- in_valid=0 is sampled as a bubble: out_valid=0 and all outputs 0.
- MUL with src1 or src2 zero still takes the full W cycles; there is no early exit.
- Back-to-back MULs: the second is sampled in the DONE cycle of the first, with no idle gap.

## Configuration
- EXEC_MUL_EN defined: MUL state machine, counter and stall logic are present.
- EXEC_MUL_EN undefined: opcode 10 is treated as undefined (res 0, latency 1). out_stall is tied 0, and the FSM is reduced to IDLE only.

## Structure
- Shared package swt16_pkg: ALU opcode localparams (ALU_NOP..ALU_MUL), ALU_OP_WIDTH, FSM state encoding.
- Sub-module ialu_mul_iter: iterative shift-add multiplier.
  - Inputs: start, a, b.
  - Outputs: busy, done, product.
  - Instantiated only under EXEC_MUL_EN.

## Test plan
- Reset released, no valid input → all outputs 0, out_stall 0.
- ADD 0xFFFF+0x0002 → next cycle out_res=0x0001, out_valid=1. SUB 0x0003-0x0005 → 0xFFFE.
- SRA 0x8000 by 4 → 0xF800. SLL 0x0001 by 15 → 0x8000. Undefined op 15 → res 0.
- Jump via PASS2 src2=0x0ABC → out_set_pc=1, out_flush=1, out_branch_pc=0xABC for exactly one cycle.
- MUL 0x0123*0x0011 (EXEC_MUL_EN) → out_stall high for 16 cycles, then out_res=0x1353, out_valid=1. Upstream change during stall is ignored.
- Reset asserted in MUL cycle 5 → outputs 0 immediately. After release, ADD 1+1 → out_res=2 with latency 1.
